// File: rtl/dense_engine_if.sv
// dense_engine_if: operand read bus between the dense engine and its operand store.
interface dense_engine_if #(
    parameter int ADDR_W = 4
);
    logic              mem_rd;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        x_data;
    logic [7:0]        w_data;
    modport master (output mem_rd, x_addr, w_addr, input x_data, w_data);
    modport slave  (input mem_rd, x_addr, w_addr, output x_data, w_data);
endinterface

// File: rtl/dense_engine_ctrl.sv
// dense_engine_ctrl: sequences one IN_LEN-long dot product over int8/int4/int2 operands
// and returns the saturated signed result.
module dense_engine_ctrl #(
    parameter int IN_LEN = 16,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_prec,
    input  logic [1:0]              prec_in,
    input  logic                    run_dense,
    output logic                    dense_done,
    output logic                    busy,
    output logic signed [OUT_W-1:0] y_out,
    output logic                    y_valid,
    dense_engine_if.master          mem
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

    localparam logic [ADDR_W-1:0]       LAST  = ADDR_W'(IN_LEN - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    state_t                  state_q, state_d;
    logic [1:0]              prec_q, prec_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ADDR_W-1:0]       cnt_q, cnt_d;
    logic signed [OUT_W-1:0] y_q, y_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    rd_q, rd_d;
    logic                    rd_dly_q;
    logic signed [15:0]      prod;

    // Narrow modes keep only the low bits of each operand byte and sign-extend them.
    function automatic logic signed [7:0] ext(input logic [7:0] v, input logic [1:0] p);
        return p == 2'b01 ? {{4{v[3]}}, v[3:0]} : p == 2'b10 ? {{6{v[1]}}, v[1:0]} : v;
    endfunction

    assign prod = ext(mem.x_data, prec_q) * ext(mem.w_data, prec_q);

    always_comb begin
        state_d = state_q;
        prec_d  = prec_q;
        acc_d   = rd_dly_q ? acc_q + ACC_W'(prod) : acc_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        rd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_prec && prec_in != 2'b11) prec_d = prec_in;
                if (run_dense) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    rd_d    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                rd_d    = cnt_q != LAST;
                cnt_d   = cnt_q + ADDR_W'(1);
                state_d = cnt_q == LAST ? S_DRAIN : S_RUN;
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                y_d     = acc_q > Y_MAX ? Y_MAX[OUT_W-1:0] :
                          acc_q < Y_MIN ? Y_MIN[OUT_W-1:0] : acc_q[OUT_W-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prec_q   <= 2'b00;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            rd_dly_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prec_q   <= prec_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            rd_dly_q <= rd_q;
        end
    end

    assign mem.mem_rd = rd_q;
    assign mem.x_addr = cnt_q;
    assign mem.w_addr = cnt_q;
    assign dense_done = done_q;
    assign y_valid    = done_q;
    assign busy       = busy_q;
    assign y_out      = y_q;
endmodule

// File: tb/tb_dense_engine_ctrl.sv
// tb_dense_engine_ctrl: directed runs of dense_engine_ctrl against hand-computed results.
module tb_dense_engine_ctrl;
    logic              clk;
    logic              rst_n;
    logic              load_prec;
    logic [1:0]        prec_in;
    logic              run_dense;
    logic              dense_done;
    logic              busy;
    logic signed [7:0] y_out;
    logic              y_valid;
    logic [7:0]        xm[16];
    logic [7:0]        wm[16];
    int                n_chk = 0;
    int                n_fail = 0;

    dense_engine_if #(.ADDR_W(4)) bus();

    dense_engine_ctrl #(.IN_LEN(16), .ADDR_W(4), .ACC_W(24), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_prec(load_prec), .prec_in(prec_in),
        .run_dense(run_dense), .dense_done(dense_done), .busy(busy),
        .y_out(y_out), .y_valid(y_valid), .mem(bus)
    );

    always #5 clk = ~clk;

    // Operand store: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.x_data <= xm[bus.x_addr];
            bus.w_data <= wm[bus.w_addr];
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] x, input logic [7:0] w);
        for (int i = 0; i < 16; i++) begin
            xm[i] = x;
            wm[i] = w;
        end
    endtask

    task automatic load(input logic [1:0] pv);
        @(negedge clk);
        load_prec = 1'b1;
        prec_in   = pv;
        @(posedge clk); #1;
        load_prec = 1'b0;
    endtask

    task automatic run(input string tag, input int exp_y, input bit lp, input logic [1:0] pv,
                       input bit inj, input bit stop);
        int nrd = 0;
        int done_at = 0;
        int ndone = 0;
        int bad_addr = 0;
        bit fin = 0;
        @(negedge clk);
        run_dense = 1'b1;
        load_prec = lp;
        prec_in   = pv;
        @(posedge clk); #1;
        run_dense = 1'b0;
        load_prec = 1'b0;
        chk({tag, " busy_start"}, busy, 1);
        for (int k = 1; k <= 24 && !fin; k++) begin
            if (bus.mem_rd) begin
                if (bus.x_addr != 4'(nrd) || bus.w_addr != bus.x_addr) bad_addr++;
                nrd++;
            end
            @(posedge clk); #1;
            if (inj && k == 5) begin
                run_dense = 1'b1;
                load_prec = 1'b1;
                prec_in   = 2'b10;
            end else begin
                run_dense = 1'b0;
                load_prec = 1'b0;
            end
            if (k == 17) chk({tag, " busy_mid"}, busy, 1);
            if (dense_done) begin
                ndone++;
                done_at = k;
                chk({tag, " y_valid"}, y_valid, 1);
                fin = stop;
            end
        end
        chk({tag, " rd_cycles"}, nrd, 16);
        chk({tag, " addr_order"}, bad_addr, 0);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " done_edge"}, done_at, 18);
        chk({tag, " y_out"}, y_out, exp_y);
        chk({tag, " busy_end"}, busy, 0);
        if (!stop) chk({tag, " done_low"}, dense_done, 0);
    endtask

    initial begin
        int ndone;
        clk       = 1'b0;
        rst_n     = 1'b0;
        run_dense = 1'b0;
        load_prec = 1'b0;
        prec_in   = 2'b00;
        fill(8'd2, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst y_out", y_out, 0);
        chk("rst busy", busy, 0);
        chk("rst done", dense_done, 0);
        chk("rst y_valid", y_valid, 0);
        chk("rst mem_rd", bus.mem_rd, 0);
        chk("rst x_addr", bus.x_addr, 0);
        chk("rst w_addr", bus.w_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("int8_2x3", 96, 0, 2'b00, 0, 0);
        fill(8'd127, 8'd127);
        run("sat_pos", 127, 0, 2'b00, 0, 0);
        fill(8'h80, 8'd127);
        run("sat_neg", -128, 0, 2'b00, 0, 0);
        for (int i = 0; i < 16; i++) begin
            xm[i] = 8'(i);
            wm[i] = i < 4 ? 8'(i) : 8'd0;
        end
        run("ramp", 14, 0, 2'b00, 0, 0);

        fill(8'hFF, 8'h07);
        load(2'b01);
        run("int4", -112, 0, 2'b00, 0, 0);
        run("ignore_busy", -112, 0, 2'b00, 1, 0);
        run("ignore_hold", -112, 0, 2'b00, 0, 0);

        fill(8'h03, 8'h01);
        run("int2_same_edge", -16, 1, 2'b10, 0, 0);
        load(2'b11);
        run("reserved_hold", -16, 0, 2'b00, 0, 0);

        fill(8'd2, 8'd3);
        @(negedge clk);
        run_dense = 1'b1;
        @(posedge clk); #1;
        run_dense = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst y_out", y_out, 0);
        chk("midrst busy", busy, 0);
        chk("midrst mem_rd", bus.mem_rd, 0);
        chk("midrst x_addr", bus.x_addr, 0);
        chk("midrst done", dense_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            if (dense_done) ndone++;
        end
        chk("midrst no_done", ndone, 0);

        fill(8'h03, 8'h01);
        run("prec_after_rst", 48, 0, 2'b00, 0, 0);
        run("b2b_first", 48, 0, 2'b00, 0, 1);
        fill(8'd2, 8'd3);
        run("b2b_second", 96, 0, 2'b00, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
